burst_mem_controller: RTL and testbench

Parametrised paged burst memory controller on the multiplexed AddrData bus. Claims a transaction when the page field of a valid address matches `PAGE`, then runs a fixed-length read or write burst of `BURST_LEN` beats against an internal synchronous-read memory. It generalises the fixed four-beat, 16-bit, 256-word controller in width, depth and burst length, and adds:

- registered read data with exact latency;
- a busy/done handshake;
- defined reset-abort behaviour.

---
 rtl/burst_mem_pkg.sv | 37 +++
 rtl/burst_mem_array.sv | 32 +++
 rtl/burst_mem_controller.sv | 138 +++++++++++++
 tb/tb_burst_mem_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_mem_pkg.sv
// -----------------------------------------------------------------------------
// burst_mem_pkg
// Shared types and helpers for the paged burst memory controller.
//   state_t         : controller FSM state (IDLE, BURST)
//   next_burst_addr : word address of beat 'beat' in a burst starting at
//                     'base', in linear or critical-word-first wrap mode.
// -----------------------------------------------------------------------------
package burst_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Linear: (base + beat) mod 2^addr_w.
  // Wrap:   the low log2(burst_len) bits roll over inside the aligned block,
  //         the upper bits stay those of base. burst_len is a power of two.
  function automatic logic [31:0] next_burst_addr(
    input logic [31:0] base,
    input logic [31:0] beat,
    input int unsigned addr_w,
    input int unsigned burst_len,
    input logic        wrap
  );
    logic [31:0] addr_mask;
    logic [31:0] blk_mask;
    logic [31:0] sum;
    addr_mask = (32'h1 << addr_w) - 32'h1;
    blk_mask  = burst_len - 32'h1;
    sum       = base + beat;
    if (wrap) begin
      return ((base & ~blk_mask) | (sum & blk_mask)) & addr_mask;
    end
    return sum & addr_mask;
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// -----------------------------------------------------------------------------
// burst_mem_array
// 2^ADDR_W x DATA_W single-clock memory, no reset.
//   clk     : clock
//   wr_en   : write strobe, mem[wr_addr] <= wr_data at posedge
//   wr_addr : write word address
//   wr_data : write data
//   rd_addr : read word address
//   rd_data : registered read data, mem[rd_addr] one cycle after rd_addr
// -----------------------------------------------------------------------------
module burst_mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/burst_mem_controller.sv
// -----------------------------------------------------------------------------
// burst_mem_controller
// Paged burst memory controller on a multiplexed address/data bus.
// Optional build macro: BURST_MEM_WRAP_EN selects critical-word-first wrap
// addressing; left undefined, bursts increment linearly mod 2^MEM_ADDR_W.
//
// Ports:
//   clk       : clock, all logic on posedge
//   resetL    : synchronous active-low reset
//   AddrValid : address phase qualifier
//   rw        : 1 = read, 0 = write, sampled with AddrValid
//   AddrData  : multiplexed address/data bus (tri-state)
//   busy      : high while a burst is in progress (state == BURST)
//   done      : one-cycle pulse on the final beat
//
// Handshake: the CPU presents an address with AddrValid in cycle A. If the
// page field matches PAGE and the controller is idle, it claims the bus and
// beats run in cycles A+1..A+BURST_LEN with busy high; done marks the last
// beat. Read data is driven by the controller for the whole beat; write data
// is driven by the CPU for the whole beat and stored at the edge ending it.
// AddrValid during BURST is ignored; the next address may follow in A+BURST_LEN+1.
// -----------------------------------------------------------------------------
module burst_mem_controller
  import burst_mem_pkg::*;
#(
  parameter int                   DATA_W     = 16,
  parameter int                   PAGE_BITS  = 4,
  parameter logic [PAGE_BITS-1:0] PAGE       = 4'h2,
  parameter int                   MEM_ADDR_W = 8,
  parameter int                   BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              resetL,
  input  logic              AddrValid,
  input  logic              rw,
  inout  wire  [DATA_W-1:0] AddrData,
  output logic              busy,
  output logic              done
);

  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
`ifdef BURST_MEM_WRAP_EN
  localparam logic WRAP_MODE = 1'b1;
`else
  localparam logic WRAP_MODE = 1'b0;
`endif

  state_t                  state, state_next;
  logic [BEAT_W-1:0]       beat, beat_next;
  logic [MEM_ADDR_W-1:0]   base;
  logic                    is_read;
  logic                    claim;
  logic                    last_beat;
  logic [MEM_ADDR_W-1:0]   cur_addr;
  logic [MEM_ADDR_W-1:0]   nxt_addr;
  logic [MEM_ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic                    wr_en;
  logic                    drive_bus;

  assign claim     = (state == IDLE) && AddrValid &&
                     (AddrData[DATA_W-1 -: PAGE_BITS] == PAGE);
  assign last_beat = (beat == LAST_BEAT);

  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        if (claim) begin
          state_next = BURST;
          beat_next  = '0;
        end
      end
      BURST: begin
        beat_next = beat + BEAT_W'(1);
        if (last_beat) begin
          state_next = IDLE;
          beat_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetL) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Burst context only matters while in BURST, so it needs no reset.
  always_ff @(posedge clk) begin
    if (claim) begin
      base    <= AddrData[MEM_ADDR_W-1:0];
      is_read <= rw;
    end
  end

  assign cur_addr = MEM_ADDR_W'(next_burst_addr(32'(base), 32'(beat),
                                                MEM_ADDR_W, BURST_LEN, WRAP_MODE));
  assign nxt_addr = MEM_ADDR_W'(next_burst_addr(32'(base), 32'(beat) + 32'd1,
                                                MEM_ADDR_W, BURST_LEN, WRAP_MODE));

  // The read port is one cycle ahead of the beat: in the address phase it
  // looks at the bus offset (beat 0), in beat k it fetches beat k+1.
  assign rd_addr = (state == BURST) ? nxt_addr : AddrData[MEM_ADDR_W-1:0];

  // A write beat coinciding with a reset edge is dropped.
  assign wr_en     = (state == BURST) && !is_read && resetL;
  assign drive_bus = (state == BURST) && is_read;

  burst_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cur_addr),
    .wr_data (AddrData),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign AddrData = drive_bus ? rd_data : {DATA_W{1'bz}};

  assign busy = (state == BURST);
  assign done = (state == BURST) && last_beat;

endmodule

// File: tb/tb_burst_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_burst_mem_controller
// Directed bench for burst_mem_controller: a vector table of bursts plus
// hand-written sequences for reset abort, back-to-back and idle qualifiers,
// and a second instance with DATA_W=32, MEM_ADDR_W=10, BURST_LEN=8, PAGE=A.
// Buses carry pull-ups, so a released bus reads as all ones.
// -----------------------------------------------------------------------------
module tb_burst_mem_controller;

  localparam int BL = 4;
  localparam logic [15:0] IDLE16 = 16'hFFFF;
  localparam logic [31:0] IDLE32 = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetL;

  // ---------------- DUT 16-bit ----------------
  logic        av, rw, oe, busy, done;
  logic [15:0] drv;
  tri   [15:0] bus;
  assign bus = oe ? drv : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu16
    pullup (bus[g]);
  end

  burst_mem_controller u_dut (
    .clk       (clk),
    .resetL    (resetL),
    .AddrValid (av),
    .rw        (rw),
    .AddrData  (bus),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- DUT 32-bit sweep ----------------
  logic        av2, rw2, oe2, busy2, done2;
  logic [31:0] drv2;
  tri   [31:0] bus2;
  assign bus2 = oe2 ? drv2 : 32'hzzzz_zzzz;
  for (genvar g = 0; g < 32; g++) begin : g_pu32
    pullup (bus2[g]);
  end

  burst_mem_controller #(
    .DATA_W     (32),
    .PAGE_BITS  (4),
    .PAGE       (4'hA),
    .MEM_ADDR_W (10),
    .BURST_LEN  (8)
  ) u_dut32 (
    .clk       (clk),
    .resetL    (resetL),
    .AddrValid (av2),
    .rw        (rw2),
    .AddrData  (bus2),
    .busy      (busy2),
    .done      (done2)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             rd;
    logic [15:0]      addr;
    logic [3:0][15:0] data;   // write words, or expected read words
    logic             claim;
  } vec_t;

  function automatic logic [3:0][15:0] w4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  vec_t vecs[12];

  // ---------------- driver tasks ----------------
  task automatic addr_phase(input logic rd, input logic [15:0] a);
    av  = 1'b1;
    rw  = rd;
    drv = a;
    oe  = 1'b1;
    @(posedge clk); #1;
    av  = 1'b0;
    rw  = 1'b0;
  endtask

  // Beats of one burst. probe=1 raises AddrValid (read) in the final beat,
  // which the controller must ignore.
  task automatic run_beats(input logic rd, input logic [3:0][15:0] d,
                           input logic claim, input logic probe);
    logic [31:0] e;
    for (int k = 0; k < BL; k++) begin
      if (rd) oe = 1'b0;
      else begin
        oe  = 1'b1;
        drv = d[k];
      end
      if (probe && k == BL - 1) begin
        av = 1'b1;
        rw = 1'b1;
      end
      if (rd && claim) exp_q.push_back(32'(d[k]));
      @(negedge clk);
      check("busy", 32'(busy), 32'(claim));
      check("done", 32'(done), 32'(claim && k == BL - 1));
      if (rd) begin
        if (claim) begin
          e = exp_q.pop_front();
          check("rdata", 32'(bus), e);
        end else begin
          check("bus_idle", 32'(bus), 32'(IDLE16));
        end
      end
      @(posedge clk); #1;
    end
    av = 1'b0;
    rw = 1'b0;
    oe = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("post_busy", 32'(busy), 32'd0);
    check("post_bus", 32'(bus), 32'(IDLE16));
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] e;
    logic [3:0][15:0] d1, dm, db;

    d1 = w4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    dm = w4(16'h5550, 16'h5551, 16'h5552, 16'h5553);
    vecs[0]  = '{1'b0, 16'h2010, d1, 1'b1};
    vecs[1]  = '{1'b1, 16'h2010, d1, 1'b1};
    vecs[2]  = '{1'b1, 16'h3010, d1, 1'b0};
    vecs[3]  = '{1'b0, 16'h3010, w4(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD), 1'b0};
    vecs[4]  = '{1'b1, 16'h2010, d1, 1'b1};
    vecs[5]  = '{1'b0, 16'h20FE, w4(16'hA0FE, 16'hA0FF, 16'hA000, 16'hA001), 1'b1};
    vecs[6]  = '{1'b1, 16'h20FE, w4(16'hA0FE, 16'hA0FF, 16'hA000, 16'hA001), 1'b1};
    vecs[7]  = '{1'b0, 16'h2004, w4(16'h0404, 16'h0505, 16'h0606, 16'h0707), 1'b1};
    vecs[8]  = '{1'b0, 16'h2006, w4(16'hB006, 16'hB007, 16'hB008, 16'hB009), 1'b1};
`ifdef BURST_MEM_WRAP_EN
    // wrap: the write at 06 landed at 06, 07, 04, 05
    vecs[9]  = '{1'b1, 16'h2004, w4(16'hB008, 16'hB009, 16'hB006, 16'hB007), 1'b1};
`else
    // linear: the write at 06 landed at 06..09, leaving 04/05 intact
    vecs[9]  = '{1'b1, 16'h2004, w4(16'h0404, 16'h0505, 16'hB006, 16'hB007), 1'b1};
`endif
    // middle bits [11:8] are ignored: 0x2540 addresses offset 0x40
    vecs[10] = '{1'b0, 16'h2540, dm, 1'b1};
    vecs[11] = '{1'b1, 16'h2040, dm, 1'b1};

    resetL = 1'b0;
    av = 1'b0; rw = 1'b0; oe = 1'b0; drv = '0;
    av2 = 1'b0; rw2 = 1'b0; oe2 = 1'b0; drv2 = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus", 32'(bus), 32'(IDLE16));
    check("rst_busy32", 32'(busy2), 32'd0);
    @(posedge clk); #1;
    resetL = 1'b1;
    @(posedge clk); #1;

    // table-driven bursts
    for (int i = 0; i < 12; i++) begin
      addr_phase(vecs[i].rd, vecs[i].addr);
      run_beats(vecs[i].rd, vecs[i].data, vecs[i].claim, 1'b0);
      idle_check();
    end

    // matching page without AddrValid: no claim
    drv = 16'h2010; oe = 1'b1; av = 1'b0;
    @(posedge clk); #1;
    oe = 1'b0;
    @(negedge clk);
    check("noav_busy", 32'(busy), 32'd0);
    check("noav_bus", 32'(bus), 32'(IDLE16));
    @(posedge clk); #1;

    // reset during beat 2 of a write at 0x2040: only 40, 41 updated
    addr_phase(1'b0, 16'h2040);
    drv = 16'h9990;
    @(negedge clk);
    check("abort_busy0", 32'(busy), 32'd1);
    @(posedge clk); #1;
    drv = 16'h9991;
    @(posedge clk); #1;
    drv = 16'h9992;
    resetL = 1'b0;
    @(posedge clk); #1;
    resetL = 1'b1;
    oe = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bus", 32'(bus), 32'(IDLE16));
    @(posedge clk); #1;
    addr_phase(1'b1, 16'h2040);
    run_beats(1'b1, w4(16'h9990, 16'h9991, 16'h5552, 16'h5553), 1'b1, 1'b0);
    idle_check();

    // reset during beat 1 of a read: bus released after the edge
    addr_phase(1'b1, 16'h2010);
    oe = 1'b0;
    @(negedge clk);
    check("rabort_d0", 32'(bus), 32'h1111);
    @(posedge clk); #1;
    resetL = 1'b0;
    @(negedge clk);
    check("rabort_d1", 32'(bus), 32'h2222);
    @(posedge clk); #1;
    resetL = 1'b1;
    @(negedge clk);
    check("rabort_busy", 32'(busy), 32'd0);
    check("rabort_bus", 32'(bus), 32'(IDLE16));
    @(posedge clk); #1;

    // back-to-back: AddrValid in the done cycle (bus = 0x2090) is ignored,
    // the address in the following cycle starts a new burst
    db = w4(16'hC000, 16'hC001, 16'hC002, 16'h2090);
    addr_phase(1'b0, 16'h2080);
    run_beats(1'b0, db, 1'b1, 1'b1);
    av = 1'b1; rw = 1'b1; drv = 16'h2080; oe = 1'b1;
    @(negedge clk);
    check("b2b_gap_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    av = 1'b0; rw = 1'b0;
    run_beats(1'b1, db, 1'b1, 1'b0);
    idle_check();

    // 32-bit, 10-bit address, 8-beat instance
    av2 = 1'b1; rw2 = 1'b0; drv2 = 32'hA000_0100; oe2 = 1'b1;
    @(posedge clk); #1;
    av2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drv2 = 32'h1000_0000 + 32'(k);
      @(negedge clk);
      check("w32_busy", 32'(busy2), 32'd1);
      check("w32_done", 32'(done2), 32'(k == 7));
      @(posedge clk); #1;
    end
    oe2 = 1'b0;
    @(negedge clk);
    check("w32_idle", 32'(busy2), 32'd0);
    @(posedge clk); #1;
    av2 = 1'b1; rw2 = 1'b1; drv2 = 32'hA000_0100; oe2 = 1'b1;
    @(posedge clk); #1;
    av2 = 1'b0; rw2 = 1'b0; oe2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(32'h1000_0000 + 32'(k));
      @(negedge clk);
      e = exp_q.pop_front();
      check("r32_data", bus2, e);
      check("r32_done", 32'(done2), 32'(k == 7));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("r32_bus_idle", bus2, IDLE32);
    check("r32_busy_idle", 32'(busy2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
